// File: rtl/phase_error_detector.sv
// Counter-based phase detector: counts clk cycles between synchronised ref/fb
// rising edges and reports a saturated signed error plus a lock indicator.
module phase_error_detector #(
  parameter int ERR_WIDTH  = 8,
  parameter int CNT_WIDTH  = 12,
  parameter int TIMEOUT    = 4095,
  parameter int LOCK_TOL   = 2,
  parameter int LOCK_COUNT = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        ref_in,
  input  logic                        fb_in,
  output logic signed [ERR_WIDTH-1:0] err_out,
  output logic                        err_valid,
  output logic                        lock
);

  localparam int LCNT_WIDTH = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0]        MAXE_CNT    = CNT_WIDTH'((1 << (ERR_WIDTH - 1)) - 1);
  localparam logic signed [ERR_WIDTH-1:0] MAXE        = ERR_WIDTH'((1 << (ERR_WIDTH - 1)) - 1);
  localparam logic signed [ERR_WIDTH-1:0] TOL         = ERR_WIDTH'(LOCK_TOL);
  localparam logic [CNT_WIDTH-1:0]        TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0]        CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [LCNT_WIDTH-1:0]       LCNT_MAX    = LCNT_WIDTH'(LOCK_COUNT);
  localparam logic [LCNT_WIDTH-1:0]       LCNT_ONE    = LCNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    FB_LEAD  = 2'd2
  } state_t;

  logic [2:0]                  ref_sync_r;
  logic [2:0]                  fb_sync_r;
  logic [1:0]                  vld_r;
  logic                        ref_arm_r;
  logic                        fb_arm_r;
  logic                        ref_rise_s;
  logic                        fb_rise_s;
  state_t                      state_r;
  state_t                      state_s;
  logic [CNT_WIDTH-1:0]        cnt_r;
  logic [CNT_WIDTH-1:0]        cnt_s;
  logic                        emit_s;
  logic signed [ERR_WIDTH-1:0] val_s;
  logic [LCNT_WIDTH-1:0]       lcnt_r;
  logic [LCNT_WIDTH-1:0]       lcnt_s;

  function automatic logic signed [ERR_WIDTH-1:0] clamp_cnt(input logic [CNT_WIDTH-1:0] c);
    logic signed [ERR_WIDTH-1:0] r;
    if (c > MAXE_CNT) r = MAXE;
    else              r = $signed(c[ERR_WIDTH-1:0]);
    return r;
  endfunction

  function automatic logic in_tol(input logic signed [ERR_WIDTH-1:0] v);
    logic signed [ERR_WIDTH-1:0] mag;
    if (v[ERR_WIDTH-1]) mag = -v;
    else                mag = v;
    return (mag <= TOL);
  endfunction

  // Synchronisers plus history flop; an input must be seen low after reset
  // (arm flag) before its rising edge counts, so a level held across reset is ignored.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ref_sync_r <= 3'b000;
      fb_sync_r  <= 3'b000;
      vld_r      <= 2'b00;
      ref_arm_r  <= 1'b0;
      fb_arm_r   <= 1'b0;
    end else begin
      ref_sync_r <= {ref_sync_r[1:0], ref_in};
      fb_sync_r  <= {fb_sync_r[1:0], fb_in};
      vld_r      <= {vld_r[0], 1'b1};
      ref_arm_r  <= ref_arm_r | (vld_r[1] & ~ref_sync_r[1]);
      fb_arm_r   <= fb_arm_r | (vld_r[1] & ~fb_sync_r[1]);
    end
  end

  assign ref_rise_s = ref_sync_r[1] & ~ref_sync_r[2] & ref_arm_r;
  assign fb_rise_s  = fb_sync_r[1] & ~fb_sync_r[2] & fb_arm_r;

  // Window FSM next-state, counter and emit decode
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    emit_s  = 1'b0;
    val_s   = {ERR_WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (ref_rise_s && fb_rise_s) begin
          emit_s = 1'b1;
          val_s  = {ERR_WIDTH{1'b0}};
        end else if (ref_rise_s) begin
          state_s = REF_LEAD;
          cnt_s   = CNT_ONE;
        end else if (fb_rise_s) begin
          state_s = FB_LEAD;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = IDLE;
        end
      end
      REF_LEAD: begin
        if (fb_rise_s && !ref_rise_s) begin
          emit_s  = 1'b1;
          val_s   = clamp_cnt(cnt_r);
          state_s = IDLE;
        end else if (fb_rise_s && ref_rise_s) begin
          emit_s = 1'b1;
          val_s  = clamp_cnt(cnt_r);
          cnt_s  = CNT_ONE;
        end else if (ref_rise_s) begin
          emit_s = 1'b1;
          val_s  = MAXE;
          cnt_s  = CNT_ONE;
        end else if (cnt_r == TIMEOUT_CNT) begin
          emit_s  = 1'b1;
          val_s   = MAXE;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      FB_LEAD: begin
        if (ref_rise_s && !fb_rise_s) begin
          emit_s  = 1'b1;
          val_s   = -clamp_cnt(cnt_r);
          state_s = IDLE;
        end else if (ref_rise_s && fb_rise_s) begin
          emit_s = 1'b1;
          val_s  = -clamp_cnt(cnt_r);
          cnt_s  = CNT_ONE;
        end else if (fb_rise_s) begin
          emit_s = 1'b1;
          val_s  = -MAXE;
          cnt_s  = CNT_ONE;
        end else if (cnt_r == TIMEOUT_CNT) begin
          emit_s  = 1'b1;
          val_s   = -MAXE;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_WIDTH{1'b0}};
      end
    endcase
  end

  // Consecutive in-tolerance window counter, saturating at LOCK_COUNT
  always_comb begin
    lcnt_s = lcnt_r;
    if (emit_s) begin
      if (!in_tol(val_s))         lcnt_s = {LCNT_WIDTH{1'b0}};
      else if (lcnt_r == LCNT_MAX) lcnt_s = LCNT_MAX;
      else                         lcnt_s = lcnt_r + LCNT_ONE;
    end else begin
      lcnt_s = lcnt_r;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_WIDTH{1'b0}};
      lcnt_r    <= {LCNT_WIDTH{1'b0}};
      err_out   <= {ERR_WIDTH{1'b0}};
      err_valid <= 1'b0;
      lock      <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      lcnt_r    <= lcnt_s;
      err_valid <= emit_s;
      if (emit_s) err_out <= val_s;
      else        err_out <= err_out;
      lock      <= (lcnt_r == LCNT_MAX);
    end
  end

endmodule

// File: tb/tb_phase_error_detector.sv
// Directed bench for phase_error_detector: window values, saturation, slip,
// timeout, lock hysteresis and reset behaviour with hand-computed expectations.
module tb_phase_error_detector;

  logic              clk;
  logic              rstn;
  logic              ref_in;
  logic              fb_in;
  logic signed [7:0] err_out;
  logic              err_valid;
  logic              lock;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic signed [7:0] val_q[$];
  int                cyc_q[$];
  logic              lock_q[$];

  phase_error_detector #(
    .ERR_WIDTH (8),
    .CNT_WIDTH (12),
    .TIMEOUT   (4095),
    .LOCK_TOL  (2),
    .LOCK_COUNT(4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .ref_in   (ref_in),
    .fb_in    (fb_in),
    .err_out  (err_out),
    .err_valid(err_valid),
    .lock     (lock)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Each err_valid pulse cycle is logged with its value and the lock level
  always @(negedge clk) begin
    if (err_valid === 1'b1) begin
      val_q.push_back(err_out);
      cyc_q.push_back(cyc);
      lock_q.push_back(lock);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_err(input string tag, input int exp, input int budget,
                            output int pc, output logic lk);
    int k;
    k  = 0;
    pc = -1;
    lk = 1'b0;
    while (val_q.size() == 0 && k < budget) begin
      wait_cycles(1);
      k++;
    end
    if (val_q.size() == 0) begin
      check_val({tag, "_timeout"}, 0, 1);
    end else begin
      check_val(tag, int'(val_q.pop_front()), exp);
      pc = cyc_q.pop_front();
      lk = lock_q.pop_front();
    end
  endtask

  // gap > 0: ref leads by gap cycles; gap < 0: fb leads; gap == 0: together
  task automatic run_window(input string tag, input int gap, input int exp,
                            output int lat, output logic lk_pulse, output logic lk_after);
    int c0;
    int pc;
    if (gap > 0) begin
      ref_in = 1'b1;
      wait_cycles(gap);
      fb_in = 1'b1;
    end else if (gap < 0) begin
      fb_in = 1'b1;
      wait_cycles(-gap);
      ref_in = 1'b1;
    end else begin
      ref_in = 1'b1;
      fb_in  = 1'b1;
    end
    c0 = cyc;
    expect_err(tag, exp, 20, pc, lk_pulse);
    lat      = pc - c0;
    lk_after = lock;
    ref_in = 1'b0;
    fb_in  = 1'b0;
    wait_cycles(4);
  endtask

  initial begin
    int   lat;
    int   pc;
    int   c0;
    logic lkp;
    logic lka;

    rstn   = 1'b0;
    ref_in = 1'b0;
    fb_in  = 1'b0;

    for (int i = 0; i < 3; i++) begin
      ref_in = (i % 2 == 0);
      fb_in  = (i % 2 == 1);
      wait_cycles(1);
      check_val("rst_err_out", int'(err_out), 0);
      check_val("rst_err_valid", int'(err_valid), 0);
      check_val("rst_lock", int'(lock), 0);
    end
    ref_in = 1'b1;
    fb_in  = 1'b1;
    rstn   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_cycles(1);
      check_val("rel_err_valid", int'(err_valid), 0);
    end
    wait_cycles(3);
    check_val("rel_no_pulse", val_q.size(), 0);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    wait_cycles(4);

    run_window("ref_lead5", 5, 5, lat, lkp, lka);
    check_val("ref_lead5_latency", lat, 3);
    check_val("hold_err_out", int'(err_out), 5);
    check_val("hold_err_valid", int'(err_valid), 0);

    run_window("fb_lead3", -3, -3, lat, lkp, lka);
    check_val("fb_lead3_raw", int'($unsigned(err_out)), 32'hFD);

    run_window("simultaneous", 0, 0, lat, lkp, lka);
    check_val("simultaneous_latency", lat, 3);

    run_window("fb_late200", 200, 127, lat, lkp, lka);

    ref_in = 1'b1;
    wait_cycles(3);
    ref_in = 1'b0;
    wait_cycles(3);
    ref_in = 1'b1;
    c0 = cyc;
    expect_err("slip", 127, 20, pc, lkp);
    check_val("slip_latency", pc - c0, 3);
    while (cyc < c0 + 4) wait_cycles(1);
    fb_in = 1'b1;
    expect_err("slip_next_window", 4, 20, pc, lkp);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    wait_cycles(4);
    check_val("slip_extra_pulses", val_q.size(), 0);

    ref_in = 1'b1;
    c0 = cyc;
    wait_cycles(3);
    ref_in = 1'b0;
    expect_err("timeout", 127, 4200, pc, lkp);
    check_val("timeout_cycle", pc - c0, 4098);
    wait_cycles(4);
    run_window("after_timeout", -5, -5, lat, lkp, lka);

    run_window("lock_w1", 1, 1, lat, lkp, lka);
    check_val("lock_w1_after", int'(lka), 0);
    run_window("lock_w2", -2, -2, lat, lkp, lka);
    check_val("lock_w2_after", int'(lka), 0);
    run_window("lock_w3", 0, 0, lat, lkp, lka);
    check_val("lock_w3_after", int'(lka), 0);
    run_window("lock_w4", 1, 1, lat, lkp, lka);
    check_val("lock_w4_at_pulse", int'(lkp), 0);
    check_val("lock_w4_after", int'(lka), 1);
    run_window("unlock_w5", 3, 3, lat, lkp, lka);
    check_val("unlock_w5_at_pulse", int'(lkp), 1);
    check_val("unlock_w5_after", int'(lka), 0);

    ref_in = 1'b1;
    wait_cycles(10);
    rstn = 1'b0;
    wait_cycles(3);
    check_val("midrst_err_out", int'(err_out), 0);
    check_val("midrst_err_valid", int'(err_valid), 0);
    rstn = 1'b1;
    wait_cycles(10);
    check_val("midrst_no_pulse", val_q.size(), 0);
    ref_in = 1'b0;
    wait_cycles(4);
    run_window("post_reset2", 2, 2, lat, lkp, lka);

    wait_cycles(5);
    check_val("no_stray_pulses", val_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/phase_error_detector.md
# phase_error_detector

Counter-based digital phase detector that sits directly upstream of the loop filter in the DPLL. It compares rising edges of the reference clock and the divided feedback clock, counts the `clk` cycles between them, and delivers a saturated signed phase error. The error drives the loop filter's signed input. It also provides a consecutive-window lock indicator.

## Interface
- `ERR_WIDTH`, 8: output error width in bits. Matches the loop filter input width.
- `CNT_WIDTH`, 12: internal window counter width.
- `TIMEOUT`, 4095: maximum window length in cycles before forced closure. Must be < 2^CNT_WIDTH.
- `LOCK_TOL`, 2: maximum |err| that still counts as in-tolerance.
- `LOCK_COUNT`, 16: number of consecutive in-tolerance windows required to assert `lock`.

Ports:
- `clk` input 1: system clock. Reset is `rstn`, synchronous, active-low; clock is `clk`.
- `rstn` input 1: synchronous active-low reset.
- `ref_in` input 1: reference clock, asynchronous to `clk`.
- `fb_in` input 1: feedback clock, asynchronous to `clk`.
- `err_out` output ERR_WIDTH signed: last measured phase error, held between updates.
- `err_valid` output 1: one-cycle pulse marking a new `err_out`.
- `lock` output 1: lock indicator.

## Operation
- **Synchronisation and edge detect.** `ref_in` and `fb_in` each pass through a 2-flop synchroniser plus a history flop. `ref_rise = s2 & ~s3`, and `fb_rise` is built the same way. The two paths are identical, so their delays are equal.
- **Sign convention.** Positive error means ref leads fb.
- **Saturation.** MAXE = 2^(ERR_WIDTH-1) - 1, i.e. 127 at the default width. Results are clamped to ±MAXE; -128 is never produced.
- **State machine:**
  - **IDLE**
    - `ref_rise` & `fb_rise` together: emit 0, stay in IDLE.
    - `ref_rise` only: go to REF_LEAD, cnt <= 1.
    - `fb_rise` only: go to FB_LEAD, cnt <= 1.
  - **REF_LEAD**, on each cycle:
    - `fb_rise` without `ref_rise`: emit +min(cnt, MAXE), go to IDLE.
    - `fb_rise` with `ref_rise`: emit +min(cnt, MAXE), stay in REF_LEAD with cnt <= 1 (a new window opens).
    - `ref_rise` without `fb_rise` (cycle slip): emit +MAXE, stay in REF_LEAD with cnt <= 1.
    - Otherwise, if cnt == TIMEOUT: emit +MAXE, go to IDLE.
    - Otherwise: cnt <= cnt + 1.
  - **FB_LEAD** mirrors REF_LEAD with the roles of ref and fb swapped and the emitted values negated.
- **Emit.** On an emit, `err_out` <= value and `err_valid` <= 1. Otherwise `err_valid` <= 0 and `err_out` holds.
- **Lock counter** (`lcnt`, saturating at LOCK_COUNT), updated on each emit:
  - |value| <= LOCK_TOL: lcnt <= min(lcnt + 1, LOCK_COUNT).
  - Otherwise: lcnt <= 0.
- **Lock output.** `lock` is registered and equals (lcnt == LOCK_COUNT).
  - It deasserts on the cycle after the first out-of-tolerance emit.
  - Slip and timeout results are ±MAXE and therefore always unlock.
- **Reset.** While `rstn` is low at a `clk` edge:
  - the FSM returns to IDLE;
  - cnt, lcnt and all synchroniser flops clear to 0;
  - `err_out` = 0, `err_valid` = 0, `lock` = 0.
  
  Any open window is discarded, with no emit. After reset is released, an input that is already high does not produce an edge until it goes low and then high again.

## Timing
- **Input to pulse.** An input edge first sampled high at clock edge n produces a rise pulse during cycle n+1..n+2.
- **Input to output.** `err_out` and `err_valid` update at edge n+2 when the closing edge is sampled at edge n. Total latency is 3 clock edges from sampling.
- **Measured value.** The window value equals the number of `clk` edges between the samplings of the two input edges. Edge quantisation is ±1 cycle.
- **Pulse width.** `err_valid` is high for exactly 1 cycle per window.
- **Back-to-back emits.** Emits can occur on consecutive cycles, e.g. an IDLE emit followed by a slip. Each one produces its own pulse.
- **Input rate.** Minimum input high and low time is 2 `clk` periods. Shorter pulses may be missed; this is not an error condition.
- **Lock timing.** `lock` changes one cycle after the `err_valid` pulse that caused the change.

## Test plan
- **Reset.** Hold `rstn` = 0 for 3 cycles while toggling both inputs → `err_out` = 0, `err_valid` = 0 and `lock` = 0 throughout. No pulse appears in the 3 cycles after release.
- **Ref leads.** `ref_in` rises, `fb_in` rises 5 `clk` later → one `err_valid` pulse with `err_out` = +5. A repeat with `fb_in` leading by 3 → `err_out` = -3 (0xFD).
- **Simultaneous edges.** Both inputs rise on the same cycle → `err_out` = 0, one pulse. With `fb_in` 200 cycles late → `err_out` = +127 (saturated).
- **Slip and timeout.**
  - `ref_in` rises twice with no `fb_in` edge between → `err_out` = +127 at the second ref edge, and a new window opens. A subsequent `fb_in` edge 4 cycles later → +4.
  - A `ref_in` edge with no `fb_in` edge → `err_out` = +127 after 4095 cycles, and the FSM returns to IDLE.
- **Lock** (LOCK_COUNT = 4, LOCK_TOL = 2).
  - Windows with errors +1, -2, 0, +1 → `lock` rises one cycle after the 4th pulse.
  - A following window with error +3 → `lock` falls one cycle after that pulse.
- **Reset mid-window.** Open a ref-lead window, assert `rstn` = 0 after 10 cycles, then release → no pulse is emitted. The next clean 2-cycle window → `err_out` = +2.
